// File: rtl/core_clk_gen.sv
// ---------------------------------------------------------------------------
// core_clk_gen
//
// Programmable 50%-duty clock divider. The output runs high for 2^sel_cur
// cycles of clk_master and then low for the same time. A run request
// starts the divider, and a stop request always lets the current high phase
// finish. A new divide exponent takes effect only at a falling edge of
// clkdiv_out, so the output never shows a glitch or a short phase.
//
// Ports
//   clk_master  in   master clock (the only clock)
//   rstb        in   asynchronous active-low reset
//   en          in   run request, level-sensitive
//   div_sel     in   requested half-period exponent (SEL_W bits)
//   sel_load    in   single-cycle strobe that captures div_sel
//   clkdiv_out  out  registered divided clock, feeds the downstream /2 stage
//   tick        out  one-cycle pulse in the cycle clkdiv_out goes 0->1
//   div_active  out  high while the divider is in RUN or STOPPING
//   sel_cur     out  divide exponent currently in effect
// ---------------------------------------------------------------------------
module core_clk_gen #(
   parameter int SEL_W = 3
) (
   input  logic             clk_master,
   input  logic             rstb,
   input  logic             en,
   input  logic [SEL_W-1:0] div_sel,
   input  logic             sel_load,
   output logic             clkdiv_out,
   output logic             tick,
   output logic             div_active,
   output logic [SEL_W-1:0] sel_cur
);

   // The counter must hold 2^sel - 1 for the largest sel, 2^SEL_W - 1.
   // That value needs 2^SEL_W - 1 bits.
   localparam int CNT_W = 2**SEL_W - 1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOPPING
   } state_t;

   state_t           state;
   cnt_t             cnt;
   logic [SEL_W-1:0] sel_pend;
   logic             pend;

   cnt_t             limit;
   logic             toggle_due;
   logic             apply_sel;
   logic [SEL_W-1:0] next_sel;

   // ------------------------------------------------------------------------
   // Decode of the current phase length and of the pending select.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: each signal gets a default at the top of the block. Then no
      // path can leave a signal unassigned, and no latch is inferred.
      limit      = '0;
      toggle_due = 1'b0;
      apply_sel  = 1'b0;
      next_sel   = sel_pend;

      // limit = 2^sel_cur - 1, built by shifting an all-ones mask down.
      // sel_cur <= CNT_W, so the shift amount is never negative. At the
      // largest select the limit is the all-ones value, and cnt never wraps.
      limit      = {CNT_W{1'b1}} >> (CNT_W - int'(sel_cur));
      toggle_due = (cnt == limit);

      // A strobe in the same cycle wins over an older pending value.
      // Then a coincident strobe is applied at this edge.
      apply_sel  = sel_load | pend;
      next_sel   = sel_load ? div_sel : sel_pend;
   end

   // ------------------------------------------------------------------------
   // FSM, counter and all outputs in a single registered process.
   // ------------------------------------------------------------------------
   // NOTE: the state is updated with non-blocking assignments. Every read in
   // this block then sees the value from before the edge, whatever the order
   // of the statements.
   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         state      <= S_IDLE;
         cnt        <= '0;
         clkdiv_out <= 1'b0;
         tick       <= 1'b0;
         div_active <= 1'b0;
         sel_cur    <= '0;
         sel_pend   <= '0;
         pend       <= 1'b0;
      end else begin
         tick <= 1'b0;

         // Capture a select strobe. The branches below may clear pend
         // again when they consume the value at this same edge.
         if (sel_load) begin
            sel_pend <= div_sel;
            pend     <= 1'b1;
         end

         unique case (state)
            S_IDLE: begin
               cnt        <= '0;
               clkdiv_out <= 1'b0;
               // In IDLE the output is static. A new select can therefore
               // take effect at once. This includes a strobe on the start
               // edge, so the first high phase already uses the new value.
               if (apply_sel) begin
                  sel_cur <= next_sel;
                  pend    <= 1'b0;
               end
               if (en) begin
                  state      <= S_RUN;
                  div_active <= 1'b1;
               end
            end

            S_RUN, S_STOPPING: begin
               if (toggle_due) begin
                  clkdiv_out <= ~clkdiv_out;
                  cnt        <= '0;
                  tick       <= ~clkdiv_out;
                  // A select changes only at a falling edge, with cnt = 0.
                  // The next low phase is then the first full phase at the
                  // new length.
                  if (clkdiv_out && apply_sel) begin
                     sel_cur <= next_sel;
                     pend    <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + cnt_t'(1);
               end

               if (state == S_RUN) begin
                  if (!en) begin
                     if (!clkdiv_out && !toggle_due) begin
                        // The output is low and stays low, so stop at once.
                        state      <= S_IDLE;
                        cnt        <= '0;
                        div_active <= 1'b0;
                     end else begin
                        // The output is high or is about to change. Keep
                        // counting until the next falling edge, so no
                        // shortened high pulse leaves the block.
                        state <= S_STOPPING;
                     end
                  end
               end else begin
                  // STOPPING ignores en and ends on the falling edge.
                  if (toggle_due && clkdiv_out) begin
                     state      <= S_IDLE;
                     div_active <= 1'b0;
                  end
               end
            end

            default: begin
               state      <= S_IDLE;
               cnt        <= '0;
               clkdiv_out <= 1'b0;
               div_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_core_clk_gen
//
// Directed bench for core_clk_gen at SEL_W = 3. Inputs change and outputs
// are sampled 1 ns after each rising edge of clk_master. The expected
// waveform uses the edge count k since the phase origin. The phase origin is
// the RUN entry edge, or a falling edge where the select changed:
//   clkdiv_out = (k >> sel) & 1
//   tick       = (k mod 2^(sel+1)) == 2^sel
// ---------------------------------------------------------------------------
module tb_core_clk_gen;

   localparam int SEL_W = 3;

   logic             clk_master;
   logic             rstb;
   logic             en;
   logic [SEL_W-1:0] div_sel;
   logic             sel_load;
   logic             clkdiv_out;
   logic             tick;
   logic             div_active;
   logic [SEL_W-1:0] sel_cur;

   int n_vec;
   int n_err;

   core_clk_gen #(.SEL_W(SEL_W)) dut (
      .clk_master (clk_master),
      .rstb       (rstb),
      .en         (en),
      .div_sel    (div_sel),
      .sel_load   (sel_load),
      .clkdiv_out (clkdiv_out),
      .tick       (tick),
      .div_active (div_active),
      .sel_cur    (sel_cur)
   );

   initial clk_master = 1'b0;
   always #5 clk_master = ~clk_master;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_master);
      #1;
   endtask

   // Advance n edges and check the output and tick at each edge against the
   // closed-form waveform. Edge index k runs from k0+1 to k0+n.
   task automatic expect_run(input int sel, input int k0, input int n);
      for (int i = 1; i <= n; i++) begin
         int k;
         step();
         k = k0 + i;
         check($sformatf("out s%0d k%0d", sel, k), 32'(clkdiv_out), 32'((k >> sel) & 1));
         check($sformatf("tick s%0d k%0d", sel, k), 32'(tick),
               32'((k % (2 << sel)) == (1 << sel)));
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rstb     = 1'b0;
      en       = 1'b0;
      div_sel  = '0;
      sel_load = 1'b0;

      // Reset state.
      step();
      step();
      check("rst out", 32'(clkdiv_out), 32'd0);
      check("rst tick", 32'(tick), 32'd0);
      check("rst act", 32'(div_active), 32'd0);
      check("rst sel", 32'(sel_cur), 32'd0);
      rstb = 1'b1;

      // Basic run at sel = 2. The strobe arrives on the start edge.
      en       = 1'b1;
      sel_load = 1'b1;
      div_sel  = 3'd2;
      step();
      sel_load = 1'b0;
      check("start sel", 32'(sel_cur), 32'd2);
      check("start act", 32'(div_active), 32'd1);
      check("start out", 32'(clkdiv_out), 32'd0);
      expect_run(2, 0, 20);             // rise at k = 20

      // Clean stop: drop en one cycle after the rise. The high phase still
      // lasts 4 cycles.
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stop hi out", 32'(clkdiv_out), 32'd1);
         check("stop hi act", 32'(div_active), 32'd1);
      end
      step();
      check("stop fall out", 32'(clkdiv_out), 32'd0);
      check("stop fall act", 32'(div_active), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle out", 32'(clkdiv_out), 32'd0);
         check("idle tick", 32'(tick), 32'd0);
         check("idle act", 32'(div_active), 32'd0);
      end

      // A select loaded in IDLE, then a divide by 2.
      sel_load = 1'b1;
      div_sel  = 3'd0;
      step();
      sel_load = 1'b0;
      step();
      check("idle sel", 32'(sel_cur), 32'd0);
      en = 1'b1;
      step();
      check("d2 act", 32'(div_active), 32'd1);
      check("d2 out", 32'(clkdiv_out), 32'd0);
      expect_run(0, 0, 8);

      // Stop with a toggle due: a full high cycle is emitted, then IDLE.
      en = 1'b0;
      step();
      check("d2stop out", 32'(clkdiv_out), 32'd1);
      check("d2stop tick", 32'(tick), 32'd1);
      check("d2stop act", 32'(div_active), 32'd1);
      step();
      check("d2stop fall out", 32'(clkdiv_out), 32'd0);
      check("d2stop fall act", 32'(div_active), 32'd0);

      // Start at sel = 3, with the strobe arriving on the start edge.
      en       = 1'b1;
      sel_load = 1'b1;
      div_sel  = 3'd3;
      step();
      sel_load = 1'b0;
      check("s3 sel", 32'(sel_cur), 32'd3);
      expect_run(3, 0, 12);             // high since k = 8

      // Two strobes in one high phase (5, then 1). The last one wins, and
      // the change is applied only at the fall.
      sel_load = 1'b1;
      div_sel  = 3'd5;
      expect_run(3, 12, 1);
      check("sw mid sel a", 32'(sel_cur), 32'd3);
      div_sel  = 3'd1;
      expect_run(3, 13, 1);
      sel_load = 1'b0;
      check("sw mid sel b", 32'(sel_cur), 32'd3);
      expect_run(3, 14, 2);             // fall at k = 16
      check("sw fall sel", 32'(sel_cur), 32'd1);
      expect_run(1, 0, 11);             // 2 low / 2 high from the fall

      // A strobe that coincides with the falling edge is applied there.
      sel_load = 1'b1;
      div_sel  = 3'd0;
      expect_run(1, 11, 1);
      sel_load = 1'b0;
      check("coinc sel", 32'(sel_cur), 32'd0);
      expect_run(0, 0, 7);              // output high after k = 7

      // Asynchronous reset between edges while the output is high.
      check("pre rst out", 32'(clkdiv_out), 32'd1);
      #2;
      rstb = 1'b0;
      #1;
      check("arst out", 32'(clkdiv_out), 32'd0);
      check("arst tick", 32'(tick), 32'd0);
      check("arst act", 32'(div_active), 32'd0);
      check("arst sel", 32'(sel_cur), 32'd0);
      #1;
      rstb = 1'b1;
      step();                            // first edge behaves as IDLE
      check("rerun act", 32'(div_active), 32'd1);
      check("rerun out", 32'(clkdiv_out), 32'd0);
      expect_run(0, 0, 6);

      // STOPPING ignores en=1 until it reaches IDLE.
      en = 1'b0;
      step();
      check("ign out", 32'(clkdiv_out), 32'd1);
      en = 1'b1;
      step();
      check("ign fall out", 32'(clkdiv_out), 32'd0);
      check("ign fall act", 32'(div_active), 32'd0);
      step();
      check("restart act", 32'(div_active), 32'd1);
      check("restart out", 32'(clkdiv_out), 32'd0);
      expect_run(0, 0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
